// File: rtl/uart_transmitter.sv
// uart_transmitter: UART 8N1 serial transmitter, LSB first, line idles high.
// One serial bit lasts CLKS_PER_BIT clocks (2..512, and CLKS_PER_BIT <= 2**CNT_W).
// Optional macro UART_TX_PARITY_EN inserts a parity bit (even, or odd when
// PARITY_ODD=1) between the last data bit and the stop bit.
module uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 279,
    parameter int unsigned CNT_W        = 9,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_tx,
    input  logic             send,
    output logic             ready,
    output logic             dout,
    output logic             done,
    output logic [2:0]       state,
    output logic [2:0]       index,
    output logic [CNT_W-1:0] counter
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic             LP_PARITY_ODD = 1'(PARITY_ODD);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_counter;
    logic [CNT_W-1:0] w_counter_nxt;
    logic [2:0]       r_index;
    logic [2:0]       w_index_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_dout;
    logic             w_dout_nxt;
    logic             r_ready;
    logic             w_ready_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic             w_bit_end;
    logic [CNT_W-1:0] w_counter_inc;
    logic             w_parity;

    assign w_bit_end     = (r_counter == LP_CNT_LAST);
    assign w_counter_inc = r_counter + CNT_W'(1);
    // Parity of the latched byte; the PARITY state is only entered with the macro.
    assign w_parity      = (^r_shift) ^ LP_PARITY_ODD;

    // State and datapath registers; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_counter <= '0;
            r_index   <= '0;
            r_shift   <= '0;
            r_dout    <= 1'b1;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_counter <= w_counter_nxt;
            r_index   <= w_index_nxt;
            r_shift   <= w_shift_nxt;
            r_dout    <= w_dout_nxt;
            r_ready   <= w_ready_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state logic; dout is computed one cycle ahead so the pin comes from a flop.
    always_comb begin
        w_state_nxt   = r_state;
        w_counter_nxt = r_counter;
        w_index_nxt   = r_index;
        w_shift_nxt   = r_shift;
        w_dout_nxt    = r_dout;
        w_ready_nxt   = r_ready;
        w_done_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_dout_nxt    = 1'b1;
                w_ready_nxt   = 1'b1;
                w_counter_nxt = '0;
                w_index_nxt   = '0;
                if (send) begin
                    w_shift_nxt = data_tx;
                    w_state_nxt = S_START;
                    w_dout_nxt  = 1'b0;
                    w_ready_nxt = 1'b0;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_counter_nxt = '0;
                    w_index_nxt   = '0;
                    w_state_nxt   = S_DATA;
                    w_dout_nxt    = r_shift[0];
                end else begin
                    w_counter_nxt = w_counter_inc;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    w_counter_nxt = '0;
                    if (r_index != 3'd7) begin
                        w_index_nxt = r_index + 3'd1;
                        w_dout_nxt  = r_shift[r_index + 3'd1];
                    end else begin
                        w_index_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_dout_nxt  = w_parity;
`else
                        w_state_nxt = S_STOP;
                        w_dout_nxt  = 1'b1;
`endif
                    end
                end else begin
                    w_counter_nxt = w_counter_inc;
                end
            end

            S_PARITY: begin
                w_dout_nxt = w_parity;
                if (w_bit_end) begin
                    w_counter_nxt = '0;
                    w_state_nxt   = S_STOP;
                    w_dout_nxt    = 1'b1;
                end else begin
                    w_counter_nxt = w_counter_inc;
                end
            end

            S_STOP: begin
                w_dout_nxt = 1'b1;
                if (w_bit_end) begin
                    w_counter_nxt = '0;
                    w_state_nxt   = S_IDLE;
                    w_ready_nxt   = 1'b1;
                    w_done_nxt    = 1'b1;
                end else begin
                    w_counter_nxt = w_counter_inc;
                end
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_counter_nxt = '0;
                w_index_nxt   = '0;
                w_dout_nxt    = 1'b1;
                w_ready_nxt   = 1'b1;
            end
        endcase
    end

    assign ready   = r_ready;
    assign dout    = r_dout;
    assign done    = r_done;
    assign state   = r_state;
    assign index   = r_index;
    assign counter = r_counter;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: random bytes, back-to-back sends, busy-send
// rejection, input churn during a frame and a mid-frame reset, all checked
// cycle by cycle against an expected serial waveform built from the frame bits.
module tb_uart_transmitter;

    localparam int unsigned CPB  = 4;
    localparam int unsigned CW   = 9;
    localparam int unsigned PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FLEN = NBITS * int'(CPB);

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    data_tx;
    logic          send;
    logic          ready;
    logic          dout;
    logic          done;
    logic [2:0]    state;
    logic [2:0]    index;
    logic [CW-1:0] counter;

    int total = 0;
    int bad   = 0;

    uart_transmitter #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (CW),
        .PARITY_ODD   (PODD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_tx (data_tx),
        .send    (send),
        .ready   (ready),
        .dout    (dout),
        .done    (done),
        .state   (state),
        .index   (index),
        .counter (counter)
    );

    always #5 clk = ~clk;

    // Line bits in transmission order: bit 0 is the start bit.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic par;
        par = (^d) ^ 1'(PODD);
`ifdef UART_TX_PARITY_EN
        frame_of = {1'b1, par, d, 1'b0};
`else
        frame_of = {1'b1, 1'b1, d, 1'b0};
        if (par) frame_of[10] = 1'b1;
`endif
    endfunction

    // Expected debug state while serial bit b of the frame is on the line.
    function automatic int exp_state(input int b);
        if (b == 0) return 1;
        if (b <= 8) return 2;
        if (NBITS == 11 && b == 9) return 4;
        return 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_dout"},    32'(dout),    32'(1));
        chk({tag, "_ready"},   32'(ready),   32'(1));
        chk({tag, "_done"},    32'(done),    32'(0));
        chk({tag, "_state"},   32'(state),   32'(0));
        chk({tag, "_counter"}, 32'(counter), 32'(0));
        chk({tag, "_index"},   32'(index),   32'(0));
    endtask

    // Follows one frame whose accept edge has just been set up by the caller.
    // While busy, send and data_tx are churned (or send held high when chaining).
    task automatic run_frame(input logic [7:0] d, input bit chain, input logic [7:0] nd);
        logic [10:0] fr;
        logic [7:0]  rx;
        int          b;
        fr = frame_of(d);
        rx = 8'h00;
        for (int k = 0; k <= FLEN; k++) begin
            @(negedge clk);
            if (k < FLEN) begin
                b = k / int'(CPB);
                chk("dout",    32'(dout),    32'(fr[b]));
                chk("ready",   32'(ready),   32'(0));
                chk("done",    32'(done),    32'(0));
                chk("counter", 32'(counter), 32'(k % int'(CPB)));
                chk("state",   32'(state),   32'(exp_state(b)));
                chk("index",   32'(index),   32'((b >= 1 && b <= 8) ? b - 1 : 0));
                if ((k % int'(CPB)) == int'(CPB) / 2 && b >= 1 && b <= 8) rx[b-1] = dout;
                send    = chain ? 1'b1 : 1'($urandom_range(0, 1));
                data_tx = 8'($urandom);
            end else begin
                chk("done_pulse",  32'(done),  32'(1));
                chk("end_ready",   32'(ready), 32'(1));
                chk("end_dout",    32'(dout),  32'(1));
                chk("end_state",   32'(state), 32'(0));
                chk("rx_byte",     32'(rx),    32'(d));
                send    = chain;
                data_tx = chain ? nd : 8'($urandom);
            end
        end
        if (!chain) begin
            @(negedge clk);
            chk_idle("after");
        end
    endtask

    initial begin
        logic [7:0]  d;
        logic [10:0] fr;
        // Reset with send asserted: reset has priority.
        rst     = 1'b1;
        send    = 1'b1;
        data_tx = 8'hA5;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst  = 1'b0;
        send = 1'b0;
        @(negedge clk);
        chk_idle("idle_hold");

        // Single directed byte.
        data_tx = 8'hA5;
        send    = 1'b1;
        run_frame(8'hA5, 1'b0, 8'h00);

        // Back-to-back with send held high: one idle cycle between frames.
        data_tx = 8'h00;
        send    = 1'b1;
        run_frame(8'h00, 1'b1, 8'hFF);
        run_frame(8'hFF, 1'b0, 8'h00);

        // 0x81 frame with busy-time send pulses and data churn.
        data_tx = 8'h81;
        send    = 1'b1;
        run_frame(8'h81, 1'b0, 8'h00);

        // Random bytes with random idle gaps, some chained.
        for (int n = 0; n < 8; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk_idle("gap");
            end
            d       = 8'($urandom);
            data_tx = d;
            send    = 1'b1;
            if (n % 3 == 2) begin
                logic [7:0] d2;
                d2 = 8'($urandom);
                run_frame(d, 1'b1, d2);
                run_frame(d2, 1'b0, 8'h00);
            end else begin
                run_frame(d, 1'b0, 8'h00);
            end
        end

        // Reset in the middle of data bit 5.
        d       = 8'hC3;
        fr      = frame_of(d);
        data_tx = d;
        send    = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (6 * int'(CPB) + int'(CPB) / 2) @(negedge clk);
        chk("pre_rst_dout",  32'(dout),  32'(fr[6]));
        chk("pre_rst_index", 32'(index), 32'(5));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("midrst");
        for (int k = 0; k < FLEN + 2; k++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'(0));
            chk("post_rst_dout", 32'(dout), 32'(1));
        end
        data_tx = 8'h55;
        send    = 1'b1;
        run_frame(8'h55, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
